// File: rtl/mod10_alert_gen.sv
// mod10_alert_gen: counts accepted samples modulo MOD and pulses alert_mod10 per block, tracking blocks per frame.
// Define MOD10_ALERT_EARLY_EN to make alert_mod10 combinational, one cycle earlier.
module mod10_alert_gen #(
  parameter int MOD        = 10,
  parameter int FRAME_BLKS = 64,
  parameter int CNT_W      = $clog2(MOD),
  parameter int BLK_W      = $clog2(FRAME_BLKS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             din_valid,
  output logic             alert_mod10,
  output logic [CNT_W-1:0] cnt_mod10,
  output logic [BLK_W-1:0] blk_idx,
  output logic             frame_done,
  output logic             resync,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [BLK_W-1:0] blk_nx;
  logic wrap;
  // frame_start wins in every state; a sample on the start cycle counts as sample 0
  always_comb begin
    wrap     = state == RUN && din_valid && !frame_start && cnt_mod10 == CNT_W'(MOD - 1);
    state_nx = frame_start ? RUN
             : state == DONE ? IDLE
             : (wrap && blk_idx == BLK_W'(FRAME_BLKS - 1)) ? DONE
             : state;
    cnt_nx   = frame_start ? CNT_W'(din_valid)
             : (state == DONE || wrap) ? '0
             : (state == RUN && din_valid) ? cnt_mod10 + 1'b1
             : cnt_mod10;
    blk_nx   = (frame_start || state == DONE) ? '0
             : wrap ? blk_idx + 1'b1
             : blk_idx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_mod10  <= '0;
      blk_idx    <= '0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt_mod10  <= cnt_nx;
      blk_idx    <= blk_nx;
      frame_done <= state_nx == DONE;
      resync     <= frame_start && state == RUN;
    end
  end
`ifdef MOD10_ALERT_EARLY_EN
  assign alert_mod10 = wrap;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alert_mod10 <= 1'b0;
    else     alert_mod10 <= wrap;
  end
`endif
  assign busy = state != IDLE;
endmodule
